// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
package cpu_pkg;

  // EX-stage operand select encodings
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  // Load-use FSM: RUN = normal issue, LSTALL = extra load-use bubbles pending
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_LSTALL = 1'b1
  } hz_state_t;

  // Per-entry scoreboard flags; the destination register is stored beside
  // these because its width follows the REG_AW parameter of the instance.
  typedef struct packed {
    logic valid;
    logic regwr;
    logic is_load;
  } sb_flags_t;

  // Youngest matching producer wins; a load still in EX cannot forward.
  function automatic logic [1:0] fwd_select(input logic hit_ex,
                                            input logic hit_mem,
                                            input logic ex_is_load);
    if (hit_ex && !ex_is_load) return FWD_EXMEM;
    if (hit_mem) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight destination registers (entry 0 = EX) with
// per-entry match flags for the two ID-stage source operands.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [REG_AW-1:0] push_rw,
  input  logic              push_regwr,
  input  logic              push_is_load,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              uses_rs,
  input  logic              uses_rt,
  output logic [DEPTH-1:0]  match_rs,
  output logic [DEPTH-1:0]  match_rt,
  output logic              head_is_load
);

  sb_flags_t         flags_q [DEPTH];
  logic [REG_AW-1:0] rw_q    [DEPTH];

  // Advance every entry one stage; entry 0 takes the ID instruction or a bubble
  always_ff @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        flags_q[i] <= '0;
        rw_q[i]    <= '0;
      end
    end else begin
      flags_q[0].valid   <= push;
      flags_q[0].regwr   <= push & push_regwr;
      flags_q[0].is_load <= push & push_is_load;
      rw_q[0]            <= push_rw;
      for (int i = 1; i < DEPTH; i++) begin
        flags_q[i] <= flags_q[i-1];
        rw_q[i]    <= rw_q[i-1];
      end
    end
  end

  // Register 0 is hardwired, so it never produces a match
  always_comb begin
    match_rs = '0;
    match_rt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_rs[i] = flags_q[i].valid & flags_q[i].regwr & uses_rs &
                    (rs != '0) & (rw_q[i] == rs);
      match_rt[i] = flags_q[i].valid & flags_q[i].regwr & uses_rt &
                    (rt != '0) & (rw_q[i] == rt);
    end
    head_is_load = flags_q[0].valid & flags_q[0].is_load;
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and forwarding control beside the ID stage: load-use
// stalls, taken-branch squash, EX operand selects and perf counters.
module pipe_hazard_unit
  import cpu_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rw,
  input  logic              id_regwr,
  input  logic              id_is_load,
  input  logic              ex_br_taken,
  output logic              stall,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int                LCNT_W    = $clog2(LOAD_LAT + 1);
  localparam logic [LCNT_W-1:0] LCNT_INIT = LCNT_W'(LOAD_LAT - 1);

  hz_state_t         state_q, state_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic [DEPTH-1:0]  match_rs, match_rt;
  logic              head_is_load;
  logic              load_hit;
  logic              push;
  logic              unused_deep;

  hazard_scoreboard #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_rw      (id_rw),
    .push_regwr   (id_regwr),
    .push_is_load (id_is_load),
    .rs           (id_rs),
    .rt           (id_rt),
    .uses_rs      (id_uses_rs),
    .uses_rt      (id_uses_rt),
    .match_rs     (match_rs),
    .match_rt     (match_rt),
    .head_is_load (head_is_load)
  );

  // Entries from WB onward need no forwarding: the register file writes before it reads
  assign unused_deep = ^{match_rs, match_rt};

  assign load_hit = id_valid & head_is_load & (match_rs[0] | match_rt[0]);
  assign push     = id_valid & ~stall & ~ex_br_taken;

  // Next state and combinational stall/flush; a taken branch overrides any stall
  always_comb begin
    state_d    = state_q;
    lcnt_d     = lcnt_q;
    stall      = 1'b0;
    flush_ifid = ex_br_taken & ~rst;
    flush_idex = ex_br_taken & ~rst;
    if (ex_br_taken) begin
      state_d = ST_RUN;
      lcnt_d  = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load_hit) begin
            stall   = 1'b1;
            lcnt_d  = LCNT_INIT;
            state_d = (LOAD_LAT > 1) ? ST_LSTALL : ST_RUN;
          end
        end
        ST_LSTALL: begin
          stall = 1'b1;
          if (lcnt_q <= LCNT_W'(1)) begin
            lcnt_d  = '0;
            state_d = ST_RUN;
          end else begin
            lcnt_d = lcnt_q - LCNT_W'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
          lcnt_d  = '0;
        end
      endcase
    end
    if (rst) stall = 1'b0;
  end

  // FSM state and remaining-bubble counter
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
    end
  end

  // Operand selects follow the instruction into EX; bubbles carry register-file selects
  always_ff @(negedge clk) begin
    if (rst || stall || ex_br_taken || !id_valid) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else begin
      fwd_a <= fwd_select(match_rs[0], match_rs[1], head_is_load);
      fwd_b <= fwd_select(match_rt[0], match_rt[1], head_is_load);
    end
  end

  // Saturating stall and flush cycle counters
  always_ff @(negedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_br_taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: three instances (LOAD_LAT 1/3, CNT_W 16/4),
// each with a directed program, random traffic, an instruction-level
// reference model and a queue-based scoreboard monitor.
module tb_pipe_hazard_unit;

  typedef struct {
    bit v;
    int rs, rt;
    bit urs, urt;
    int rw;
    bit regwr, ld;
  } ins_t;

  typedef struct {
    int stall, flush, fa, fb, sc, fc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit done [3];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic ins_t mk(bit v, int rs, int rt, bit urs, bit urt,
                              int rw, bit regwr, bit ld);
    ins_t i;
    i.v = v; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    i.rw = rw; i.regwr = regwr; i.ld = ld;
    return i;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int LL   = (g == 1) ? 3 : 1;
    localparam int CW   = (g == 2) ? 4 : 16;
    localparam int DP   = (g == 1) ? 4 : 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          rst, id_valid, id_uses_rs, id_uses_rt, id_regwr, id_is_load, ex_br_taken;
    logic [4:0]    id_rs, id_rt, id_rw;
    logic          stall, flush_ifid, flush_idex;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_hazard_unit #(
      .REG_AW(5), .DEPTH(DP), .LOAD_LAT(LL), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rw(id_rw),
      .id_regwr(id_regwr), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
      .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    exp_t q[$];
    ins_t pipe [DP];      // instructions past ID, index 0 = EX
    int   owed = 0;       // load-use bubbles still to insert
    int   sc = 0, fc = 0;

    // stage of the youngest in-flight writer of r that matters (EX or MEM), else -1
    function automatic int producer(int r, bit used);
      for (int k = 0; k < 2; k++)
        if (used && r != 0 && pipe[k].v && pipe[k].regwr && pipe[k].rw == r) return k;
      return -1;
    endfunction

    task automatic step(input ins_t ins, input bit br, input bit r, output bit stalled);
      exp_t e;
      int pa, pb;
      bit hit;
      @(posedge clk); #1;
      rst = r; id_valid = ins.v; id_rs = 5'(ins.rs); id_rt = 5'(ins.rt);
      id_uses_rs = ins.urs; id_uses_rt = ins.urt; id_rw = 5'(ins.rw);
      id_regwr = ins.regwr; id_is_load = ins.ld; ex_br_taken = br;
      e = '{0, 0, 0, 0, 0, 0};
      stalled = 1'b0;
      if (r) begin
        for (int k = 0; k < DP; k++) pipe[k].v = 1'b0;
        owed = 0; sc = 0; fc = 0;
      end else begin
        pa  = producer(ins.rs, ins.urs);
        pb  = producer(ins.rt, ins.urt);
        hit = ins.v && pipe[0].ld && (pa == 0 || pb == 0);
        if (br) begin
          e.flush = 1; owed = 0;
        end else if (owed > 0) begin
          e.stall = 1; owed--;
        end else if (hit) begin
          e.stall = 1; owed = LL - 1;
        end
        if (!(e.stall || br || !ins.v)) begin
          e.fa = (pa == 0) ? 1 : (pa == 1) ? 2 : 0;
          e.fb = (pb == 0) ? 1 : (pb == 1) ? 2 : 0;
        end
        if (e.stall && sc < CMAX) sc++;
        if (br && fc < CMAX) fc++;
        for (int k = DP - 1; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = ins;
        pipe[0].v = ins.v && !e.stall && !br;
        stalled = e.stall;
      end
      e.sc = sc; e.fc = fc;
      q.push_back(e);
    endtask

    // issue one instruction, holding it in ID for as long as the model stalls
    task automatic send(input ins_t ins, input bit br);
      bit s;
      int n = 0;
      do begin
        step(ins, br, 1'b0, s);
        br = 1'b0;
        n++;
      end while (s && n < 16);
    endtask

    // monitor: combinational outputs before the falling edge, registered ones after
    initial begin
      exp_t e;
      forever begin
        @(posedge clk); #3;
        if (q.size() > 0) begin
          e = q.pop_front();
          chk($sformatf("cfg%0d stall", g), int'(stall), e.stall);
          chk($sformatf("cfg%0d flush_ifid", g), int'(flush_ifid), e.flush);
          chk($sformatf("cfg%0d flush_idex", g), int'(flush_idex), e.flush);
          @(negedge clk); #1;
          chk($sformatf("cfg%0d fwd_a", g), int'(fwd_a), e.fa);
          chk($sformatf("cfg%0d fwd_b", g), int'(fwd_b), e.fb);
          chk($sformatf("cfg%0d stall_cnt", g), int'(stall_cnt), e.sc);
          chk($sformatf("cfg%0d flush_cnt", g), int'(flush_cnt), e.fc);
        end
      end
    end

    initial begin
      ins_t nop, lw3, add_dep, ins;
      bit s, held, br, r;
      nop     = mk(0, 0, 0, 0, 0, 0, 0, 0);
      lw3     = mk(1, 1, 0, 1, 0, 3, 1, 1);   // lw  $3, 0($1)
      add_dep = mk(1, 3, 1, 1, 1, 4, 1, 0);   // add $4, $3, $1
      repeat (3) step(nop, 1'b0, 1'b1, s);
      step(nop, 1'b0, 1'b0, s);
      chk($sformatf("cfg%0d reset stall_cnt", g), int'(stall_cnt), 0);
      chk($sformatf("cfg%0d reset fwd_a", g), int'(fwd_a), 0);

      // add $3,$1,$2 ; sub $4,$3,$5
      send(mk(1, 1, 2, 1, 1, 3, 1, 0), 1'b0);
      send(mk(1, 3, 5, 1, 1, 4, 1, 0), 1'b0);
      step(nop, 1'b0, 1'b0, s);
      chk($sformatf("cfg%0d ex-fwd fwd_a", g), int'(fwd_a), 1);

      // add $3 ; unrelated ; or $6,$3,$3
      send(mk(1, 1, 2, 1, 1, 3, 1, 0), 1'b0);
      send(mk(1, 7, 8, 1, 1, 9, 1, 0), 1'b0);
      send(mk(1, 3, 3, 1, 1, 6, 1, 0), 1'b0);
      step(nop, 1'b0, 1'b0, s);
      chk($sformatf("cfg%0d mem-fwd fwd_a", g), int'(fwd_a), 2);
      chk($sformatf("cfg%0d mem-fwd fwd_b", g), int'(fwd_b), 2);
      chk($sformatf("cfg%0d no-stall stall_cnt", g), int'(stall_cnt), 0);

      // load-use: LOAD_LAT bubbles, then MEM/WB forward only if the load is still in MEM
      send(lw3, 1'b0);
      send(add_dep, 1'b0);
      step(nop, 1'b0, 1'b0, s);
      chk($sformatf("cfg%0d load-use fwd_a", g), int'(fwd_a), (LL == 1) ? 2 : 0);
      chk($sformatf("cfg%0d load-use stall_cnt", g), int'(stall_cnt), LL);

      // register 0 never hazards
      send(mk(1, 1, 0, 1, 0, 0, 1, 1), 1'b0);
      send(mk(1, 0, 0, 1, 1, 4, 1, 0), 1'b0);
      step(nop, 1'b0, 1'b0, s);
      chk($sformatf("cfg%0d r0 fwd_a", g), int'(fwd_a), 0);
      chk($sformatf("cfg%0d r0 fwd_b", g), int'(fwd_b), 0);
      chk($sformatf("cfg%0d r0 stall_cnt", g), int'(stall_cnt), LL);

      // load-use hit together with a taken branch: flush only
      send(lw3, 1'b0);
      step(add_dep, 1'b1, 1'b0, s);
      step(nop, 1'b0, 1'b0, s);
      chk($sformatf("cfg%0d br flush_cnt", g), int'(flush_cnt), 1);
      chk($sformatf("cfg%0d br stall_cnt", g), int'(stall_cnt), LL);

      // reset in the middle of a load-use stall
      send(lw3, 1'b0);
      step(add_dep, 1'b0, 1'b0, s);
      step(add_dep, 1'b0, 1'b1, s);
      step(nop, 1'b0, 1'b0, s);
      chk($sformatf("cfg%0d rst-mid stall_cnt", g), int'(stall_cnt), 0);
      chk($sformatf("cfg%0d rst-mid flush_cnt", g), int'(flush_cnt), 0);
      send(add_dep, 1'b0);

      // twenty load-use pairs: counter saturates on narrow instances
      for (int i = 0; i < 20; i++) begin
        send(lw3, 1'b0);
        send(add_dep, 1'b0);
      end
      step(nop, 1'b0, 1'b0, s);
      chk($sformatf("cfg%0d sat stall_cnt", g), int'(stall_cnt),
          (20 * LL > CMAX) ? CMAX : 20 * LL);

      // random traffic over a small register set to provoke hazards
      held = 1'b0;
      ins  = nop;
      for (int i = 0; i < 1500; i++) begin
        if (!held)
          ins = mk($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0);
        br = ($urandom_range(0, 9) == 0);
        r  = ($urandom_range(0, 299) == 0);
        step(ins, br, r, s);
        held = s;
      end
      step(nop, 1'b0, 1'b0, s);
      step(nop, 1'b0, 1'b0, s);
      done[g] = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(done[0] && done[1] && done[2]) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (!(done[0] && done[1] && done[2])) chk("run timeout", 0, 1);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard-detection and forwarding controller for the pipelined CPU, placed beside the ID stage. It tracks in-flight destination registers in a DEPTH-entry scoreboard, generates load-use stalls of configurable length, squashes younger instructions on a taken branch resolved in EX, and drives the EX-stage operand forwarding selects. Saturating performance counters record stall and flush cycles.

## Interface
- REG_AW, 5: register address width.
- DEPTH, 3: tracked post-ID stages (entry 0 = EX, 1 = MEM, 2 = WB, deeper entries allowed); minimum 2.
- LOAD_LAT, 1: stall cycles inserted per load-use hazard; minimum 1.
- CNT_W, 16: performance counter width.

- clk  in  1  pipeline clock; all state updates on the falling edge, like every pipeline register.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_AW  source registers of the ID instruction.
- id_uses_rs, id_uses_rt  in  1  each source is actually read.
- id_rw  in  REG_AW  destination register after RegDst selection.
- id_regwr  in  1  ID instruction writes the register file.
- id_is_load  in  1  ID instruction is lw.
- ex_br_taken  in  1  branch in EX resolved taken this cycle.
- stall  out  1  hold PC and IF/ID; bubble into ID/EX.
- flush_ifid, flush_idex  out  1  zero the corresponding pipeline register.
- fwd_a, fwd_b  out  2  EX operand select: 0 register file, 1 EX/MEM ALU result, 2 MEM/WB result.
- stall_cnt, flush_cnt  out  CNT_W  saturating counters.

## Operation
- Scoreboard entry: {valid, rw, regwr, is_load}. Each falling edge: entry i shifts to i+1, entry DEPTH-1 drops, entry 0 loads the ID instruction, or a bubble (valid=0) when stall, flush_idex or !id_valid.
- Match(k, r): entry k valid, regwr, rw == r, r != 0, source used. Register 0 never hazards or forwards.
- FSM states RUN, LSTALL; counter lcnt, width clog2(LOAD_LAT+1).
- RUN: load-use hit = Match(0, id_rs) or Match(0, id_rt) with entry 0 is_load. Hit and no ex_br_taken -> stall=1, lcnt<=LOAD_LAT-1; go to LSTALL if LOAD_LAT>1, else stay in RUN (the bubble clears the hit next cycle).
- LSTALL: stall=1; lcnt decrements; at lcnt==0 on the edge return to RUN. Hazard re-evaluated there from the shifted scoreboard.
- Branch: ex_br_taken -> flush_ifid=1, flush_idex=1, stall=0, combinationally in the same cycle; FSM forced to RUN, lcnt<=0. Flush overrides stall.
- Forwarding, per operand, computed in ID and registered into fwd_a/fwd_b at the edge that moves the instruction into EX: Match(0) non-load -> 1; else Match(1) -> 2; else 0. Youngest match wins. On a stall or flush edge, fwd regs load 0 (the bubble's selects).
- Deeper matches (k>=2) need no forwarding: the register file writes before it reads.
- stall_cnt increments on each edge with stall=1; flush_cnt on each edge with ex_br_taken=1; both saturate at all-ones.

## Timing
- stall, flush_ifid, flush_idex: combinational from inputs and state, valid before the falling edge.
- fwd_a/fwd_b: registered, one-cycle latency, valid during the ID instruction's EX cycle.
- Load-use costs exactly LOAD_LAT bubbles; back-to-back dependent loads each pay LOAD_LAT.
- Simultaneous load-use hit and ex_br_taken: flush only, no stall counted.
- Reset: scoreboard all invalid, FSM RUN, lcnt 0, fwd_a=fwd_b=0, counters 0; stall/flush low. Reset mid-LSTALL returns to RUN on the next edge. Reset wins over branch.

## Structure
- Shared package cpu_pkg: fwd select constants FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2; FSM state encoding; scoreboard entry typedef.
- One sub-module: hazard_scoreboard (the DEPTH-entry shift register with per-entry match outputs for rs and rt); FSM, forwarding and counters live in the top.

## Test plan
- add $3,$1,$2 then sub $4,$3,$5 -> no stall; sub sees fwd_a=1 in EX.
- add $3 then unrelated instruction then or $6,$3,$3 -> fwd_a=fwd_b=2, stall never asserted.
- lw $3 then add $4,$3,$1, LOAD_LAT=1 -> stall high one cycle, one bubble, then fwd_a=2; stall_cnt=1. Repeat with LOAD_LAT=3 -> three stall cycles, stall_cnt=3.
- lw $0 then add $4,$0,$0 -> no stall, fwd selects 0.
- Load-use hit coincident with ex_br_taken -> flush_ifid=flush_idex=1, stall=0, flush_cnt=1, stall_cnt unchanged; rst asserted during LSTALL (LOAD_LAT=3) -> all outputs 0 next cycle.
- Force CNT_W=4 and 20 consecutive stalls -> stall_cnt holds at 15.
